// File: rtl/matrix_mult_stream.sv
// matrix_mult_stream: serially loads an N x K matrix A and a K x M matrix B,
// computes C = A*B with one multiply-accumulate unit and streams the N x M
// result elements out row-major. Each result is either saturated or wrapped
// to DW bits, and a sticky flag records whether any element of the job overflowed.
module matrix_mult_stream #(
  parameter int N   = 2,
  parameter int K   = 2,
  parameter int M   = 2,
  parameter int DW  = 8,
  parameter int SAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          inValid,
  input  logic [DW-1:0] inData,
  output logic          busy,
  output logic          outValid,
  output logic [DW-1:0] outData,
  output logic          done,
  output logic          overflow
);

  // The accumulator is wide enough to hold K full-range products without overflow.
  localparam int ACC_W = 2 * DW + $clog2(K);
  localparam int NA    = N * K;
  localparam int NB    = K * M;
  localparam int AAW   = (NA > 1) ? $clog2(NA) : 1;
  localparam int BAW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int JW    = (M > 1) ? $clog2(M) : 1;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_A  = 3'd1;
  localparam logic [2:0] S_LOAD_B  = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]       state;

  // Operand storage, row-major.
  logic [DW-1:0]    a_mem [NA];
  logic [DW-1:0]    b_mem [NB];

  // Load-phase write pointers.
  logic [AAW-1:0]   la;
  logic [BAW-1:0]   lb;

  // Compute-phase loop indices: k innermost, then j, then i.
  logic [IW-1:0]    ci;
  logic [JW-1:0]    cj;
  logic [KW-1:0]    ck;

  logic [ACC_W-1:0] acc;

  // MAC datapath signals.
  logic [AAW-1:0]   a_addr;
  logic [BAW-1:0]   b_addr;
  logic [DW-1:0]    a_rd;
  logic [DW-1:0]    b_rd;
  logic [ACC_W-1:0] prod;
  logic [ACC_W-1:0] acc_next;
  logic             elem_ovf;
  logic [DW-1:0]    elem_val;
  logic             i_last;
  logic             j_last;
  logic             k_last;
  logic             la_last;
  logic             lb_last;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Operand fetch, multiply-accumulate and per-element saturate/wrap.
  always_comb begin
    // NOTE: every signal gets a value on every path through this block, so
    // no latch can be inferred even if the logic below grows conditionals.
    a_addr   = AAW'(int'(ci) * K + int'(ck));
    b_addr   = BAW'(int'(ck) * M + int'(cj));
    a_rd     = a_mem[a_addr];
    b_rd     = b_mem[b_addr];
    prod     = ACC_W'(a_rd) * ACC_W'(b_rd);
    acc_next = ((ck == '0) ? '0 : acc) + prod;
    elem_ovf = |acc_next[ACC_W-1:DW];
    elem_val = acc_next[DW-1:0];
    if (elem_ovf && (SAT != 0)) begin
      elem_val = '1;
    end
    i_last   = (ci == IW'(N - 1));
    j_last   = (cj == JW'(M - 1));
    k_last   = (ck == KW'(K - 1));
    la_last  = (la == AAW'(NA - 1));
    lb_last  = (lb == BAW'(NB - 1));
  end

  // Operand capture during the two load phases.
  always_ff @(posedge clk) begin
    // NOTE: the matrices have no reset; every job rewrites all elements
    // before any of them is read, so clearing them would only cost logic.
    if (state == S_LOAD_A && inValid) begin
      a_mem[la] <= inData;
    end
    if (state == S_LOAD_B && inValid) begin
      b_mem[lb] <= inData;
    end
  end

  // Job sequencing, loop indices, accumulator and registered result output.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout, so every register samples
    // the pre-edge values regardless of statement order.
    if (rst) begin
      state    <= S_IDLE;
      la       <= '0;
      lb       <= '0;
      ci       <= '0;
      cj       <= '0;
      ck       <= '0;
      acc      <= '0;
      outValid <= 1'b0;
      outData  <= '0;
      overflow <= 1'b0;
    end else begin
      outValid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_LOAD_A;
            la       <= '0;
            lb       <= '0;
            ci       <= '0;
            cj       <= '0;
            ck       <= '0;
            overflow <= 1'b0;
          end
        end

        S_LOAD_A: begin
          if (inValid) begin
            if (la_last) begin
              la    <= '0;
              state <= S_LOAD_B;
            end else begin
              la <= la + 1'b1;
            end
          end
        end

        S_LOAD_B: begin
          if (inValid) begin
            if (lb_last) begin
              lb    <= '0;
              state <= S_COMPUTE;
            end else begin
              lb <= lb + 1'b1;
            end
          end
        end

        S_COMPUTE: begin
          acc <= acc_next;
          if (k_last) begin
            // Final sum of C[i][j]: present it on the next cycle.
            outValid <= 1'b1;
            outData  <= elem_val;
            if (elem_ovf) begin
              overflow <= 1'b1;
            end
            ck <= '0;
            if (j_last) begin
              cj <= '0;
              if (i_last) begin
                ci    <= '0;
                state <= S_DONE;
              end else begin
                ci <= ci + 1'b1;
              end
            end else begin
              cj <= cj + 1'b1;
            end
          end else begin
            ck <= ck + 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_mult_stream.sv
// Directed testbench for matrix_mult_stream: a 2x2 saturating instance, a 2x2
// wrapping instance sharing its stimulus, and a 1x3 * 3x2 instance for gapped
// input on a non-square shape.
module tb_matrix_mult_stream;

  logic       clk;
  logic       rst;

  logic       start_s, iv_s;
  logic [7:0] id_s;
  logic       busy_s, ov_s, done_s, ovf_s;
  logic [7:0] od_s;
  logic       busy_w, ov_w, done_w, ovf_w;
  logic [7:0] od_w;

  logic       start_g, iv_g;
  logic [7:0] id_g;
  logic       busy_g, ov_g, done_g, ovf_g;
  logic [7:0] od_g;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;

  int vec [8];
  int vec_g [9];
  int st_s, st_g;

  // Monitor records (sampled on the falling edge).
  int   oa_d[$], oa_c[$], da_c[$];
  int   ow_d[$];
  int   og_d[$], og_c[$], dg_c[$];
  logic ovf_s_done, ovf_w_done;
  int   busy_fall_s, busy_rise_s;
  logic prev_busy_s = 1'b0;
  logic [7:0] prev_od = 8'd0;
  int   hold_viol = 0;

  matrix_mult_stream #(.N(2), .K(2), .M(2), .DW(8), .SAT(1)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .inValid(iv_s), .inData(id_s),
    .busy(busy_s), .outValid(ov_s), .outData(od_s), .done(done_s), .overflow(ovf_s)
  );

  matrix_mult_stream #(.N(2), .K(2), .M(2), .DW(8), .SAT(0)) dut_w (
    .clk(clk), .rst(rst), .start(start_s), .inValid(iv_s), .inData(id_s),
    .busy(busy_w), .outValid(ov_w), .outData(od_w), .done(done_w), .overflow(ovf_w)
  );

  matrix_mult_stream #(.N(1), .K(3), .M(2), .DW(8), .SAT(1)) dut_g (
    .clk(clk), .rst(rst), .start(start_g), .inValid(iv_g), .inData(id_g),
    .busy(busy_g), .outValid(ov_g), .outData(od_g), .done(done_g), .overflow(ovf_g)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ov_s) begin oa_d.push_back(int'(od_s)); oa_c.push_back(cyc); end
    if (done_s) begin da_c.push_back(cyc); ovf_s_done = ovf_s; end
    if (ov_w) ow_d.push_back(int'(od_w));
    if (done_w) ovf_w_done = ovf_w;
    if (ov_g) begin og_d.push_back(int'(od_g)); og_c.push_back(cyc); end
    if (done_g) dg_c.push_back(cyc);
    if (prev_busy_s && !busy_s) busy_fall_s = cyc;
    if (!prev_busy_s && busy_s) busy_rise_s = cyc;
    prev_busy_s = busy_s;
    if (!ov_s && od_s !== prev_od) hold_viol++;
    prev_od = od_s;
  end

  task automatic clear_mon();
    oa_d.delete(); oa_c.delete(); da_c.delete(); ow_d.delete();
    og_d.delete(); og_c.delete(); dg_c.delete();
    ovf_s_done = 1'bx; ovf_w_done = 1'bx;
    busy_fall_s = -1; busy_rise_s = -1; hold_viol = 0;
  endtask

  // Raise start for one cycle on the 2x2 pair; st_s is the cycle whose end edge accepts it.
  task automatic launch_s();
    @(posedge clk); #1;
    clear_mon();
    start_s = 1'b1;
    st_s = cyc;
  endtask

  // Stream vec with inValid continuous; optionally pulse start on element pulse_idx.
  task automatic stream_s(input int pulse_idx, input bit keep_start);
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      iv_s = 1'b1;
      id_s = 8'(vec[e]);
      if (!keep_start) start_s = (e == pulse_idx);
    end
    @(posedge clk); #1;
    iv_s = 1'b0;
    id_s = 8'hA5;
    if (!keep_start) start_s = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_s = 1'b1; iv_s = 1'b0; id_s = 8'd0;
    start_g = 1'b0; iv_g = 1'b0; id_g = 8'd0;
    clear_mon();
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (busy_s !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_s); else n_pass++;
    n_total++; if (ov_s !== 1'b0) $display("FAIL reset_outvalid: got %b want 0", ov_s); else n_pass++;
    n_total++; if (od_s !== 8'd0) $display("FAIL reset_outdata: got %0d want 0", od_s); else n_pass++;
    n_total++; if (done_s !== 1'b0) $display("FAIL reset_done: got %b want 0", done_s); else n_pass++;
    n_total++; if (ovf_s !== 1'b0) $display("FAIL reset_overflow: got %b want 0", ovf_s); else n_pass++;
    n_total++; if (busy_g !== 1'b0 || od_g !== 8'd0) $display("FAIL reset_g: got busy=%b data=%0d want 0/0", busy_g, od_g); else n_pass++;
    rst = 1'b0; start_s = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int exp_d [4];
    int got;
    exp_d = '{12, 18, 7, 10};
    vec = '{2, 5, 1, 3, 1, 4, 2, 2};
    launch_s();
    @(posedge clk); #1;
    n_total++; if (busy_s !== 1'b1) $display("FAIL basic_busy_after_start: got %b want 1", busy_s); else n_pass++;
    // This cycle already carries element 0; re-run the load from the accept edge instead.
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    launch_s();
    stream_s(-1, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    n_total++; if (oa_d.size() != 4) $display("FAIL basic_count: got %0d want 4", oa_d.size()); else n_pass++;
    for (int e = 0; e < 4; e++) begin
      got = (e < oa_d.size()) ? oa_d[e] : -1;
      n_total++; if (got != exp_d[e]) $display("FAIL basic_data[%0d]: got %0d want %0d", e, got, exp_d[e]); else n_pass++;
      got = (e < oa_c.size()) ? oa_c[e] - st_s : -1;
      n_total++; if (got != 11 + 2 * e) $display("FAIL basic_cycle[%0d]: got %0d want %0d", e, got, 11 + 2 * e); else n_pass++;
    end
    got = (da_c.size() == 1) ? da_c[0] - st_s : -1;
    n_total++; if (got != 17) $display("FAIL basic_done_cycle: got %0d want 17", got); else n_pass++;
    n_total++; if (ovf_s_done !== 1'b0) $display("FAIL basic_overflow: got %b want 0", ovf_s_done); else n_pass++;
    n_total++; if (busy_fall_s - st_s != 18) $display("FAIL basic_busy_fall: got %0d want 18", busy_fall_s - st_s); else n_pass++;
    n_total++; if (hold_viol != 0) $display("FAIL basic_outdata_hold: got %0d changes want 0", hold_viol); else n_pass++;
  endtask

  task automatic test_overflow();
    int got;
    int exp_d [4];
    vec = '{255, 255, 255, 255, 255, 255, 255, 255};
    launch_s();
    stream_s(-1, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    n_total++; if (oa_d.size() != 4 || ow_d.size() != 4) $display("FAIL ovf_count: got %0d/%0d want 4/4", oa_d.size(), ow_d.size()); else n_pass++;
    for (int e = 0; e < 4; e++) begin
      got = (e < oa_d.size()) ? oa_d[e] : -1;
      n_total++; if (got != 255) $display("FAIL ovf_sat_data[%0d]: got %0d want 255", e, got); else n_pass++;
      got = (e < ow_d.size()) ? ow_d[e] : -1;
      n_total++; if (got != 2) $display("FAIL ovf_wrap_data[%0d]: got %0d want 2", e, got); else n_pass++;
    end
    n_total++; if (ovf_s_done !== 1'b1) $display("FAIL ovf_sat_flag: got %b want 1", ovf_s_done); else n_pass++;
    n_total++; if (ovf_w_done !== 1'b1) $display("FAIL ovf_wrap_flag: got %b want 1", ovf_w_done); else n_pass++;
    n_total++; if (ovf_s !== 1'b1 || busy_s !== 1'b0) $display("FAIL ovf_sticky_idle: got ovf=%b busy=%b want 1/0", ovf_s, busy_s); else n_pass++;
    // A small follow-up job must report no overflow on either instance.
    exp_d = '{12, 18, 7, 10};
    vec = '{2, 5, 1, 3, 1, 4, 2, 2};
    launch_s();
    stream_s(-1, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    n_total++; if (ovf_s_done !== 1'b0) $display("FAIL ovf_followup_sat: got %b want 0", ovf_s_done); else n_pass++;
    n_total++; if (ovf_w_done !== 1'b0) $display("FAIL ovf_followup_wrap: got %b want 0", ovf_w_done); else n_pass++;
    for (int e = 0; e < 4; e++) begin
      got = (e < ow_d.size()) ? ow_d[e] : -1;
      n_total++; if (got != exp_d[e]) $display("FAIL ovf_followup_wrap_data[%0d]: got %0d want %0d", e, got, exp_d[e]); else n_pass++;
    end
  endtask

  task automatic test_gapped();
    int exp_d [2];
    int exp_c [2];
    int got;
    exp_d = '{22, 28};
    exp_c = '{21, 24};
    vec_g = '{1, 2, 3, 1, 2, 3, 4, 5, 6};
    @(posedge clk); #1;
    clear_mon();
    start_g = 1'b1;
    st_g = cyc;
    for (int e = 0; e < 9; e++) begin
      @(posedge clk); #1;
      start_g = 1'b0;
      iv_g = 1'b1;
      id_g = 8'(vec_g[e]);
      @(posedge clk); #1;
      iv_g = 1'b0;
      id_g = 8'(200 + e);
    end
    repeat (10) @(posedge clk);
    #1;
    n_total++; if (og_d.size() != 2) $display("FAIL gap_count: got %0d want 2", og_d.size()); else n_pass++;
    for (int e = 0; e < 2; e++) begin
      got = (e < og_d.size()) ? og_d[e] : -1;
      n_total++; if (got != exp_d[e]) $display("FAIL gap_data[%0d]: got %0d want %0d", e, got, exp_d[e]); else n_pass++;
      got = (e < og_c.size()) ? og_c[e] - st_g : -1;
      n_total++; if (got != exp_c[e]) $display("FAIL gap_cycle[%0d]: got %0d want %0d", e, got, exp_c[e]); else n_pass++;
    end
    got = (dg_c.size() == 1) ? dg_c[0] - st_g : -1;
    n_total++; if (got != 24) $display("FAIL gap_done_cycle: got %0d want 24", got); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int exp_d [4];
    int got;
    exp_d = '{12, 18, 7, 10};
    vec = '{255, 255, 255, 255, 255, 255, 255, 255};
    launch_s();
    stream_s(-1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    n_total++; if (od_s !== 8'd255 || ovf_s !== 1'b1) $display("FAIL rstmid_pre: got data=%0d ovf=%b want 255/1", od_s, ovf_s); else n_pass++;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_total++; if (busy_s !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy_s); else n_pass++;
    n_total++; if (ov_s !== 1'b0 || done_s !== 1'b0) $display("FAIL rstmid_valid_done: got %b/%b want 0/0", ov_s, done_s); else n_pass++;
    n_total++; if (od_s !== 8'd0) $display("FAIL rstmid_outdata: got %0d want 0", od_s); else n_pass++;
    n_total++; if (ovf_s !== 1'b0) $display("FAIL rstmid_overflow: got %b want 0", ovf_s); else n_pass++;
    repeat (10) @(posedge clk);
    #1;
    n_total++; if (da_c.size() != 0) $display("FAIL rstmid_no_done: got %0d done pulses want 0", da_c.size()); else n_pass++;
    vec = '{2, 5, 1, 3, 1, 4, 2, 2};
    launch_s();
    stream_s(-1, 1'b0);
    repeat (12) @(posedge clk);
    #1;
    for (int e = 0; e < 4; e++) begin
      got = (e < oa_d.size()) ? oa_d[e] : -1;
      n_total++; if (got != exp_d[e]) $display("FAIL rstmid_rerun_data[%0d]: got %0d want %0d", e, got, exp_d[e]); else n_pass++;
    end
    got = (da_c.size() == 1) ? da_c[0] - st_s : -1;
    n_total++; if (got != 17) $display("FAIL rstmid_rerun_done: got %0d want 17", got); else n_pass++;
  endtask

  task automatic test_start_busy();
    int exp_d [4];
    int got;
    exp_d = '{12, 18, 7, 10};
    vec = '{2, 5, 1, 3, 1, 4, 2, 2};
    launch_s();
    stream_s(5, 1'b0);
    @(posedge clk); #1; start_s = 1'b1;
    @(posedge clk); #1; start_s = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_total++; if (oa_d.size() != 4) $display("FAIL sbusy_count: got %0d want 4", oa_d.size()); else n_pass++;
    for (int e = 0; e < 4; e++) begin
      got = (e < oa_d.size()) ? oa_d[e] : -1;
      n_total++; if (got != exp_d[e]) $display("FAIL sbusy_data[%0d]: got %0d want %0d", e, got, exp_d[e]); else n_pass++;
      got = (e < oa_c.size()) ? oa_c[e] - st_s : -1;
      n_total++; if (got != 11 + 2 * e) $display("FAIL sbusy_cycle[%0d]: got %0d want %0d", e, got, 11 + 2 * e); else n_pass++;
    end
    got = (da_c.size() == 1) ? da_c[0] - st_s : -1;
    n_total++; if (got != 17) $display("FAIL sbusy_done_cycle: got %0d want 17", got); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int exp_d [4];
    int got;
    exp_d = '{12, 18, 7, 10};
    vec = '{2, 5, 1, 3, 1, 4, 2, 2};
    launch_s();
    stream_s(-1, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    n_total++; if (busy_s !== 1'b0) $display("FAIL b2b_idle_gap: got busy=%b want 0", busy_s); else n_pass++;
    stream_s(-1, 1'b1);
    start_s = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    n_total++; if (oa_d.size() != 8 || da_c.size() != 2) $display("FAIL b2b_counts: got %0d outputs %0d dones want 8/2", oa_d.size(), da_c.size()); else n_pass++;
    got = (da_c.size() == 2) ? busy_rise_s - da_c[0] : -1;
    n_total++; if (got != 2) $display("FAIL b2b_loada_offset: got %0d want 2", got); else n_pass++;
    got = (da_c.size() == 2) ? da_c[1] - da_c[0] : -1;
    n_total++; if (got != 18) $display("FAIL b2b_done_spacing: got %0d want 18", got); else n_pass++;
    for (int e = 0; e < 4; e++) begin
      got = (e + 4 < oa_d.size()) ? oa_d[e + 4] : -1;
      n_total++; if (got != exp_d[e]) $display("FAIL b2b_job2_data[%0d]: got %0d want %0d", e, got, exp_d[e]); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_gapped();
    test_reset_mid();
    test_start_busy();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
